aes_sub_shift_pipe: RTL and testbench

Multi-cycle AES byte-substitution engine with a valid/ready handshake on input and output. It applies the forward S-box (SubBytes) or inverse S-box (InvSubBytes) to a 128-bit state, processing LANES bytes per cycle. It optionally applies ShiftRows or InvShiftRows on output. It sits between the AddRoundKey stage and the MixColumns stage of the round datapath, and replaces the single-cycle combinational substitution with an area/throughput-selectable block.

---
 rtl/aes_sub_shift_pipe.sv | 177 +++++++++++++++++
 tb/tb_aes_sub_shift_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sub_shift_pipe.sv
// aes_sub_shift_pipe
//
// Multi-cycle AES byte-substitution engine. A 128-bit state is accepted over
// a valid/ready handshake, LANES bytes of it are passed through the forward
// or inverse S-box each cycle, and the finished block is presented with an
// optional ShiftRows (forward mode) or InvShiftRows (inverse mode) applied.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   in_valid   in_block / in_inv / in_shift are valid
//   in_ready   block can be accepted this cycle (combinational)
//   in_block   input state; byte i = in_block[8*i+7:8*i] is row i%4, column i/4
//   in_inv     0 = forward S-box, 1 = inverse S-box
//   in_shift   1 = apply (Inv)ShiftRows to the result
//   out_valid  out_block is valid
//   out_ready  downstream accepts out_block
//   out_block  result, same byte mapping as in_block
//
// Parameter LANES (1, 2, 4, 8 or 16) trades area for throughput: a block
// spends 16/LANES cycles in substitution and then waits in HOLD for at
// least one cycle, so a sustained stream runs at one block per 16/LANES+1.

module aes_sub_shift_pipe #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic         in_inv,
  input  logic         in_shift,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

  // Only lane counts that divide the 16-byte state evenly are supported.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_illegal
    $error("aes_sub_shift_pipe: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, SUB, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    work_q, work_d;
  logic            inv_q, shift_q;
  logic            accept;
  logic [7:0]      laneSub [LANES];

  assign accept = in_valid & in_ready;

  // One forward/inverse S-box pair per lane; lane l works on byte
  // cnt*LANES+l of the work register.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] laneIn;
    assign laneIn     = work_q[8*(int'(cnt_q)*LANES + l) +: 8];
    assign laneSub[l] = inv_q ? SBOX_INV[laneIn] : SBOX_FWD[laneIn];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: HOLD can hand straight over to SUB when a new block is
  // accepted on the same edge the result leaves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SUB;
      SUB:     if (cnt_q == CNT_LAST) state_d = HOLD;
      HOLD:    if (out_ready) state_d = in_valid ? SUB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    out_valid = (state_q == HOLD);
    in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
  end

  // Next values for the counter and work register. The counter parks on its
  // last value once the final group of lanes is done; only an accept
  // restarts it.
  always_comb begin
    cnt_d  = cnt_q;
    work_d = work_q;
    if (accept) begin
      cnt_d  = '0;
      work_d = in_block;
    end else if (state_q == SUB) begin
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
      for (int l = 0; l < LANES; l++) begin
        work_d[8*(int'(cnt_q)*LANES + l) +: 8] = laneSub[l];
      end
    end
  end

  // Datapath registers; mode bits are captured only when a block is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      work_q <= work_d;
      if (accept) begin
        inv_q   <= in_inv;
        shift_q <= in_shift;
      end
    end
  end

  // Output byte (r,c) comes from column c+r of the same row for ShiftRows
  // and column c-r for InvShiftRows; columns wrap modulo 4.
  always_comb begin
    out_block = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        int src;
        src = c;
        if (shift_q) src = inv_q ? ((c - r + 4) & 3) : ((c + r) & 3);
        out_block[8*(4*c + r) +: 8] = work_q[8*(4*src + r) +: 8];
      end
    end
  end

endmodule

// File: tb/tb_aes_sub_shift_pipe.sv
// tb_aes_sub_shift_pipe
//
// Drives three instances of aes_sub_shift_pipe (LANES = 4, 1 and 16) and
// compares every presented output block with an expected queue filled when
// the corresponding input block is accepted. Expected values come either
// from the FIPS-197 example constants or from a reference model whose
// S-boxes are derived from GF(2^8) inversion plus the affine transform.

module tb_aes_sub_shift_pipe;

  localparam int NC [3] = '{4, 16, 1};

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19;
  localparam logic [127:0] FIPS_SUB = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
  localparam logic [127:0] FIPS_SR  = 128'he598271e_f11141b8_ae52b4e0_305dbfd4;

  typedef struct {
    logic [127:0] data;
    int           acceptCyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inValid  [3];
  logic         inReady  [3];
  logic         outValid [3];
  logic         outReady [3];
  logic [127:0] outBlock [3];
  logic [127:0] inBlock;
  logic         inInv;
  logic         inShift;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t monExp;
  logic seenValid [3];
  int   riseCyc   [3];

  logic [7:0] sboxRef [256];
  logic [7:0] invRef  [256];

  aes_sub_shift_pipe #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_block(inBlock),
    .in_inv(inInv), .in_shift(inShift),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_block(outBlock[0])
  );

  aes_sub_shift_pipe #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_block(inBlock),
    .in_inv(inInv), .in_shift(inShift),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_block(outBlock[1])
  );

  aes_sub_shift_pipe #(.LANES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[2]), .in_ready(inReady[2]), .in_block(inBlock),
    .in_inv(inInv), .in_shift(inShift),
    .out_valid(outValid[2]), .out_ready(outReady[2]), .out_block(outBlock[2])
  );

  always #5 clk = ~clk;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] b, int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  // S-box = affine(multiplicative inverse); inverse table by inversion.
  task automatic buildTables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv;
      logic [7:0] s;
      iv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(x[7:0], y[7:0]) == 8'h01) iv = y[7:0];
      end
      s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
      sboxRef[x] = s;
      invRef[s]  = x[7:0];
    end
  endtask

  function automatic logic [127:0] refModel(logic [127:0] blk, logic inv, logic shift);
    logic [7:0]   s [16];
    logic [127:0] res;
    int           src;
    for (int i = 0; i < 16; i++) s[i] = inv ? invRef[blk[8*i +: 8]] : sboxRef[blk[8*i +: 8]];
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!shift)   src = c;
        else if (inv) src = (c + 4 - r) % 4;
        else          src = (c + r) % 4;
        res[8*(4*c + r) +: 8] = s[4*src + r];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] randBlock();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(int d, logic [127:0] data, int ac);
    exp_t e;
    e.data      = data;
    e.acceptCyc = ac;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qSize(int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t popExp(int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Present a block to DUT d and wait (bounded) for the accept edge; the
  // expected result is queued with the cycle number of that edge.
  task automatic applyStimulus(input int d, input logic [127:0] blk, input logic inv,
                               input logic shift, input logic [127:0] expData, output int acc);
    inBlock    = blk;
    inInv      = inv;
    inShift    = shift;
    inValid[d] = 1'b1;
    acc        = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (inReady[d]) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d accept timeout: got in_ready 0 expected 1", d);
      inValid[d] = 1'b0;
    end else begin
      pushExp(d, expData, acc);
      @(posedge clk);
      #1;
      inValid[d] = 1'b0;
    end
  endtask

  task automatic waitDrain();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (qSize(0) + qSize(1) + qSize(2) == 0) break;
    end
    checkOutput("drain pending", 128'(qSize(0) + qSize(1) + qSize(2)), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int prevAcc;
    logic [127:0] blkA;
    logic [127:0] blkB;
    logic rInv;
    logic rShift;

    rst_n   = 1'b0;
    inBlock = '0;
    inInv   = 1'b0;
    inShift = 1'b0;
    for (int d = 0; d < 3; d++) begin
      inValid[d]   = 1'b0;
      outReady[d]  = 1'b1;
      seenValid[d] = 1'b0;
      riseCyc[d]   = 0;
    end
    buildTables();

    fork
      begin : monitor
        forever begin
          @(posedge clk);
          cyc++;
          @(negedge clk);
          for (int d = 0; d < 3; d++) begin
            if (outValid[d] && !seenValid[d]) begin
              seenValid[d] = 1'b1;
              riseCyc[d]   = cyc;
            end
            if (outValid[d] && outReady[d]) begin
              if (qSize(d) == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut%0d unexpected output: got %h expected none", d, outBlock[d]);
              end else begin
                monExp = popExp(d);
                checkOutput($sformatf("dut%0d data", d), outBlock[d], monExp.data);
                checkOutput($sformatf("dut%0d latency", d), 128'(riseCyc[d] - monExp.acceptCyc), 128'(NC[d]));
              end
              seenValid[d] = 1'b0;
            end
          end
        end
      end
    join_none

    // Reset state of every instance.
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("dut%0d reset out_valid", d), 128'(outValid[d]), 128'd0);
      checkOutput($sformatf("dut%0d reset in_ready", d), 128'(inReady[d]), 128'd1);
      checkOutput($sformatf("dut%0d reset out_block", d), outBlock[d], 128'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All-zero block through the forward S-box.
    applyStimulus(0, 128'd0, 1'b0, 1'b0, {16{8'h63}}, acc);
    waitDrain();
    checkOutput("zero block back to idle out_valid", 128'(outValid[0]), 128'd0);

    // FIPS-197 round-1 vectors on every lane width, forward and inverse.
    for (int d = 0; d < 3; d++) begin
      applyStimulus(d, FIPS_IN, 1'b0, 1'b0, FIPS_SUB, acc);
      applyStimulus(d, FIPS_IN, 1'b0, 1'b1, FIPS_SR, acc);
      applyStimulus(d, FIPS_SR, 1'b1, 1'b1, FIPS_IN, acc);
    end
    waitDrain();

    // Backpressure: result held in HOLD while the next block waits.
    outReady[0] = 1'b0;
    blkA = randBlock();
    blkB = randBlock();
    applyStimulus(0, blkA, 1'b0, 1'b1, refModel(blkA, 1'b0, 1'b1), acc);
    repeat (NC[0]) @(posedge clk);
    #1;
    checkOutput("bp hold out_valid", 128'(outValid[0]), 128'd1);
    fork
      applyStimulus(0, blkB, 1'b1, 1'b0, refModel(blkB, 1'b1, 1'b0), acc);
      begin
        repeat (10) begin
          @(negedge clk);
          checkOutput("bp stable out_block", outBlock[0], refModel(blkA, 1'b0, 1'b1));
          checkOutput("bp in_ready", 128'(inReady[0]), 128'd0);
        end
        @(posedge clk);
        #1;
        outReady[0] = 1'b1;
      end
    join
    waitDrain();

    // Back-to-back random streams with random modes.
    for (int d = 0; d < 3; d++) begin
      prevAcc = 0;
      for (int k = 0; k < ((d == 0) ? 8 : 4); k++) begin
        blkA   = randBlock();
        rInv   = 1'($urandom_range(0, 1));
        rShift = 1'($urandom_range(0, 1));
        applyStimulus(d, blkA, rInv, rShift, refModel(blkA, rInv, rShift), acc);
        if (k > 0) checkOutput($sformatf("dut%0d stream period", d), 128'(acc - prevAcc), 128'(NC[d] + 1));
        prevAcc = acc;
      end
      waitDrain();
    end

    // Reset in the middle of substitution (counter at 2).
    blkA = randBlock();
    applyStimulus(0, blkA, 1'b0, 1'b0, refModel(blkA, 1'b0, 1'b0), acc);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    q0.delete();
    seenValid[0] = 1'b0;
    checkOutput("rst mid-sub out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("rst mid-sub in_ready", 128'(inReady[0]), 128'd1);
    checkOutput("rst mid-sub out_block", outBlock[0], 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst release in_ready", 128'(inReady[0]), 128'd1);
    checkOutput("rst release out_block", outBlock[0], 128'd0);

    // Reset while holding a finished block.
    outReady[0] = 1'b0;
    blkA = randBlock();
    applyStimulus(0, blkA, 1'b1, 1'b1, refModel(blkA, 1'b1, 1'b1), acc);
    repeat (NC[0]) @(posedge clk);
    #1;
    checkOutput("rst hold pre out_valid", 128'(outValid[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    q0.delete();
    seenValid[0] = 1'b0;
    checkOutput("rst hold out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("rst hold in_ready", 128'(inReady[0]), 128'd1);
    checkOutput("rst hold out_block", outBlock[0], 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    outReady[0] = 1'b1;

    // Normal operation after reset.
    blkA   = randBlock();
    rInv   = 1'($urandom_range(0, 1));
    rShift = 1'($urandom_range(0, 1));
    applyStimulus(0, blkA, rInv, rShift, refModel(blkA, rInv, rShift), acc);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
